// File: rtl/tl_sensor_cond.sv
// Detector debounce + per-lane saturating queue counters feeding Ta/Tal/Tb/Tbl.
// Define TL_SENSOR_SYNC_EN to add a 2-flop synchronizer on each arr_* input (+2 cycles latency).
module tl_sensor_cond #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arr_a,
  input  logic             arr_al,
  input  logic             arr_b,
  input  logic             arr_bl,
  input  logic             dep_a,
  input  logic             dep_al,
  input  logic             dep_b,
  input  logic             dep_bl,
  output logic             Ta,
  output logic             Tal,
  output logic             Tb,
  output logic             Tbl,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_al,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_bl,
  output logic [3:0]       ovf
);

  localparam logic [3:0]       DB_LAST = 4'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0] arr_in;
  logic [3:0] dep_in;
  logic [3:0] raw;

  assign arr_in = {arr_bl, arr_b, arr_al, arr_a};
  assign dep_in = {dep_bl, dep_b, dep_al, dep_a};

`ifdef TL_SENSOR_SYNC_EN
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= arr_in;
      sync2_q <= sync1_q;
    end
  end

  assign raw = sync2_q;
`else
  assign raw = arr_in;
`endif

  logic [3:0]       f_q, f_d;
  logic [3:0]       fprev_q;
  logic [3:0]       arr_ev;
  logic [3:0]       ovf_q, ovf_d;
  logic [3:0]       s_q   [4];
  logic [3:0]       s_d   [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // One arrival per clean rising edge of the debounced level.
  assign arr_ev = f_q & ~fprev_q;

  always_comb begin
    f_d   = f_q;
    ovf_d = ovf_q;
    for (int i = 0; i < 4; i++) begin
      s_d[i]   = s_q[i];
      cnt_d[i] = cnt_q[i];

      if (raw[i] != f_q[i]) begin
        if (s_q[i] == DB_LAST) begin
          f_d[i] = raw[i];
          s_d[i] = '0;
        end else begin
          s_d[i] = s_q[i] + 4'd1;
        end
      end else begin
        s_d[i] = '0;
      end

      // Coincident arrival and departure cancel, even at 0 or full.
      case ({arr_ev[i], dep_in[i]})
        2'b10: begin
          if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
          else                     cnt_d[i] = cnt_q[i] + 1'b1;
        end
        2'b01: begin
          if (cnt_q[i] != '0) cnt_d[i] = cnt_q[i] - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      f_q     <= '0;
      fprev_q <= '0;
      ovf_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        s_q[i]   <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      f_q     <= f_d;
      fprev_q <= f_q;
      ovf_q   <= ovf_d;
      for (int i = 0; i < 4; i++) begin
        s_q[i]   <= s_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cnt_a  = cnt_q[0];
  assign cnt_al = cnt_q[1];
  assign cnt_b  = cnt_q[2];
  assign cnt_bl = cnt_q[3];
  assign Ta     = (cnt_q[0] != '0);
  assign Tal    = (cnt_q[1] != '0);
  assign Tb     = (cnt_q[2] != '0);
  assign Tbl    = (cnt_q[3] != '0);
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Bench for tl_sensor_cond: directed scenarios plus random traffic against a sample-window model.
module tb_tl_sensor_cond;

  localparam int DB  = 4;
  localparam int CW  = 4;
  localparam int MAX = 15;
`ifdef TL_SENSOR_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    arr_v;
  logic [3:0]    dep_v;
  logic          Ta, Tal, Tb, Tbl;
  logic [CW-1:0] cnt_a, cnt_al, cnt_b, cnt_bl;
  logic [3:0]    ovf;
  logic [CW-1:0] cnt_o [4];
  logic [3:0]    t_o;

  int checks = 0;
  int errors = 0;

  // Model: a detector change is accepted once the last DB samples all disagree with the clean level.
  int       m_cnt  [4];
  bit       m_f    [4];
  bit       m_pend [4];
  bit [14:0] m_hist [4];
  bit [3:0] m_ovf;
  bit [3:0] m_s1, m_s2;

  tl_sensor_cond #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .arr_a(arr_v[0]), .arr_al(arr_v[1]), .arr_b(arr_v[2]), .arr_bl(arr_v[3]),
    .dep_a(dep_v[0]), .dep_al(dep_v[1]), .dep_b(dep_v[2]), .dep_bl(dep_v[3]),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .cnt_a(cnt_a), .cnt_al(cnt_al), .cnt_b(cnt_b), .cnt_bl(cnt_bl),
    .ovf(ovf)
  );

  assign cnt_o[0] = cnt_a;
  assign cnt_o[1] = cnt_al;
  assign cnt_o[2] = cnt_b;
  assign cnt_o[3] = cnt_bl;
  assign t_o      = {Tbl, Tb, Tal, Ta};

  always #5 clk = ~clk;

  function automatic void model_step(bit rst, bit [3:0] a, bit [3:0] d);
    bit raw;
    bit all_diff;
    if (rst) begin
      for (int l = 0; l < 4; l++) begin
        m_cnt[l] = 0; m_f[l] = 0; m_pend[l] = 0; m_hist[l] = '0;
      end
      m_ovf = '0; m_s1 = '0; m_s2 = '0;
      return;
    end
    for (int l = 0; l < 4; l++) begin
      raw = (SD != 0) ? m_s2[l] : a[l];
      if (m_pend[l] && !d[l]) begin
        if (m_cnt[l] == MAX) m_ovf[l] = 1'b1;
        else                 m_cnt[l]++;
      end else if (d[l] && !m_pend[l] && m_cnt[l] > 0) begin
        m_cnt[l]--;
      end
      m_hist[l] = {m_hist[l][13:0], raw};
      all_diff = 1'b1;
      for (int k = 0; k < DB; k++) if (m_hist[l][k] == m_f[l]) all_diff = 1'b0;
      m_pend[l] = all_diff && raw;
      if (all_diff) m_f[l] = raw;
    end
    m_s2 = m_s1;
    m_s1 = a;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(reset, arr_v, dep_v);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; arr_v = '0; dep_v = '0;
    tick();
    reset = 1'b0;
  endtask

  // Drives one clean arrival (6 high, 6 low) on a lane; optional dep pulse at edge dep_at.
  task automatic arrive(int lane, int dep_at);
    for (int i = 1; i <= 12; i++) begin
      arr_v[lane] = (i <= 6);
      dep_v[lane] = (i == dep_at);
      tick();
    end
    dep_v[lane] = 1'b0;
  endtask

  task automatic depart(int lane);
    dep_v[lane] = 1'b1; tick();
    dep_v[lane] = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      arr_v = 4'($urandom); dep_v = 4'($urandom);
      tick();
      checks++;
      if ({t_o, cnt_a, cnt_al, cnt_b, cnt_bl, ovf} !== '0) begin
        errors++;
        $display("FAIL reset_state cycle %0d: T=%b cnt=%h/%h/%h/%h ovf=%b, expected all zero",
                 c, t_o, cnt_a, cnt_al, cnt_b, cnt_bl, ovf);
      end
    end
    reset = 1'b0; arr_v = '0; dep_v = '0;
  endtask

  task automatic test_hold();
    int exp;
    do_reset();
    arr_v[0] = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      exp = (i >= DB + 1 + SD) ? 1 : 0;
      checks++;
      if (cnt_a !== CW'(exp) || Ta !== (exp != 0)) begin
        errors++;
        $display("FAIL hold_a edge %0d: cnt_a=%0d Ta=%b, expected cnt_a=%0d", i, cnt_a, Ta, exp);
      end
    end
    arr_v[0] = 1'b0;
    repeat (4) tick();
    arr_v[0] = 1'b1;
    repeat (4 + 1 + SD) tick();
    checks++;
    if (cnt_a !== CW'(2)) begin
      errors++;
      $display("FAIL rearrive_a: cnt_a=%0d, expected 2", cnt_a);
    end
    arr_v[0] = 1'b0;
  endtask

  task automatic test_glitch();
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) begin
        arr_v[2] = (i < 3);
        tick();
        checks++;
        if (cnt_b !== '0 || Tb !== 1'b0) begin
          errors++;
          $display("FAIL glitch_b rep %0d edge %0d: cnt_b=%0d Tb=%b, expected 0/0", r, i, cnt_b, Tb);
        end
      end
    end
    repeat (SD + 2) tick();
    checks++;
    if (cnt_b !== '0) begin
      errors++;
      $display("FAIL glitch_b_final: cnt_b=%0d, expected 0", cnt_b);
    end
  endtask

  task automatic test_saturate();
    int ec;
    do_reset();
    for (int k = 1; k <= 17; k++) begin
      arrive(1, 0);
      ec = (k > MAX) ? MAX : k;
      checks++;
      if (cnt_al !== CW'(ec) || ovf !== ((k >= 16) ? 4'b0010 : 4'b0000)) begin
        errors++;
        $display("FAIL sat_al arrival %0d: cnt_al=%0d ovf=%b, expected cnt_al=%0d", k, cnt_al, ovf, ec);
      end
    end
    for (int k = 1; k <= 15; k++) depart(1);
    checks++;
    if (cnt_al !== '0 || Tal !== 1'b0 || ovf !== 4'b0010) begin
      errors++;
      $display("FAIL drain_al: cnt_al=%0d Tal=%b ovf=%b, expected 0/0/0010", cnt_al, Tal, ovf);
    end
    depart(1);
    checks++;
    if (cnt_al !== '0 || ovf !== 4'b0010) begin
      errors++;
      $display("FAIL underflow_al: cnt_al=%0d ovf=%b, expected 0/0010", cnt_al, ovf);
    end
  endtask

  task automatic test_coincide();
    do_reset();
    repeat (3) arrive(3, 0);
    checks++;
    if (cnt_bl !== CW'(3)) begin
      errors++;
      $display("FAIL fill_bl: cnt_bl=%0d, expected 3", cnt_bl);
    end
    arrive(3, DB + 1 + SD);
    checks++;
    if (cnt_bl !== CW'(3)) begin
      errors++;
      $display("FAIL coincide_bl_3: cnt_bl=%0d, expected 3", cnt_bl);
    end
    repeat (3) depart(3);
    arrive(3, DB + 1 + SD);
    checks++;
    if (cnt_bl !== '0 || ovf[3] !== 1'b0 || Tbl !== 1'b0) begin
      errors++;
      $display("FAIL coincide_bl_0: cnt_bl=%0d ovf3=%b Tbl=%b, expected 0/0/0", cnt_bl, ovf[3], Tbl);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    arr_v[0] = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (Ta) break;
    end
    checks++;
    if (n !== DB + 1 + SD || Ta !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: Ta rose at edge %0d (Ta=%b), expected edge %0d", n, Ta, DB + 1 + SD);
    end
    arr_v[0] = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 699) == 0);
      for (int l = 0; l < 4; l++) begin
        if ($urandom_range(0, 5) == 0) arr_v[l] = ~arr_v[l];
        dep_v[l] = ($urandom_range(0, 6) == 0);
      end
      tick();
      for (int l = 0; l < 4; l++) begin
        checks++;
        if (cnt_o[l] !== CW'(m_cnt[l]) || t_o[l] !== (m_cnt[l] != 0) || ovf[l] !== m_ovf[l]) begin
          errors++;
          $display("FAIL random cycle %0d lane %0d: cnt=%0d T=%b ovf=%b, expected cnt=%0d ovf=%b",
                   c, l, cnt_o[l], t_o[l], ovf[l], m_cnt[l], m_ovf[l]);
        end
      end
    end
    reset = 1'b0; arr_v = '0; dep_v = '0;
  endtask

  initial begin
    reset = 1'b1; arr_v = '0; dep_v = '0;
    test_reset();
    test_hold();
    test_glitch();
    test_saturate();
    test_coincide();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
